ifu_fetch_seq: RTL

//  Instruction fetch unit that sits directly upstream of the main decoder/controller.
//  - Holds the PC and fetches one word per instruction from instruction memory over a req/ready handshake.
//  - Latches the word into an instruction register and presents it to the controller and datapath with a one-cycle instr_valid strobe.
//  - During that strobe it consumes npc_sel/zero to pick PC+4, branch or jump target.

---
 rtl/ifu_fetch_seq_if.sv | 27 ++
 rtl/ifu_fetch_seq.sv | 92 +++++++++
 2 files changed

// File: rtl/ifu_fetch_seq_if.sv
// Fetch-unit bundle: instruction-memory handshake plus the decoded-instruction view.
// master = fetch unit, slave = memory/controller side.
interface ifu_fetch_seq_if #(
  parameter int CNT_W = 32
);
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ready;
  logic [31:0]      imem_rdata;
  logic [31:0]      instr;
  logic             instr_valid;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             npc_sel;
  logic             zero;
  logic [CNT_W-1:0] retired;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, retired,
    input  imem_ready, imem_rdata, npc_sel, zero
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, retired,
    output imem_ready, imem_rdata, npc_sel, zero
  );
endinterface

// File: rtl/ifu_fetch_seq.sv
// Instruction fetch sequencer: PC, instruction register, next-PC select.
// Latency 2 cycles/instr (fetch + exec); each imem_ready=0 cycle holds the fetch.
module ifu_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  ifu_fetch_seq_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC
  } state_t;

  state_t           state;
  logic [31:0]      pc_q;
  logic [31:0]      instr_q;
  logic [CNT_W-1:0] retired_q;
  logic             req_q;
  logic             vld_q;

  logic [31:0]      pc_plus4;
  logic [31:0]      j_tgt;
  logic [31:0]      b_tgt;
  logic [31:0]      npc;
  logic             is_j;

  assign pc_plus4 = pc_q + 32'd4;
  assign is_j     = (instr_q[31:26] == 6'b000010);
  assign j_tgt    = {pc_plus4[31:28], instr_q[25:0], 2'b00};
  assign b_tgt    = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // npc_sel/zero only matter in S_EXEC; npc is consumed nowhere else.
  always_comb begin
    npc = pc_plus4;
    if (bus.npc_sel && is_j) begin
      npc = j_tgt;
    end else if (bus.npc_sel && bus.zero) begin
      npc = b_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      retired_q <= '0;
      req_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
          req_q <= 1'b1;
        end
        S_FETCH: begin
          if (bus.imem_ready) begin
            instr_q <= bus.imem_rdata;
            req_q   <= 1'b0;
            vld_q   <= 1'b1;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          pc_q      <= npc;
          retired_q <= retired_q + CNT_W'(1);
          vld_q     <= 1'b0;
          req_q     <= 1'b1;
          state     <= S_FETCH;
        end
        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
          vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = vld_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.retired     = retired_q;

endmodule
